// File: rtl/button_pkg.sv
// Shared types and default constants for the push-button conditioning path.
package button_pkg;

  // Per-channel debounce/repeat state.
  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    HELD_DELAY = 2'd1,
    HELD_RPT   = 2'd2
  } chan_state_t;

  localparam int DEF_N_BTN            = 3;
  localparam int DEF_TICK_DIV         = 50000;
  localparam int DEF_DEBOUNCE_TICKS   = 20;
  localparam int DEF_RPT_DELAY_TICKS  = 400;
  localparam int DEF_RPT_PERIOD_TICKS = 100;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: debounce FSM, stable counter (dc), repeat counter (rc)
// and the registered level / press / release / sticky event outputs.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_TICKS   = DEF_DEBOUNCE_TICKS,
  parameter int RPT_DELAY_TICKS  = DEF_RPT_DELAY_TICKS,
  parameter int RPT_PERIOD_TICKS = DEF_RPT_PERIOD_TICKS
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_s,
  input  logic i_tick,
  input  logic i_ack,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_evt
);

  localparam int RC_MAX = (RPT_DELAY_TICKS > RPT_PERIOD_TICKS) ? RPT_DELAY_TICKS
                                                                : RPT_PERIOD_TICKS;
  localparam int DCW = cnt_width(DEBOUNCE_TICKS);
  localparam int RCW = cnt_width(RC_MAX);

  localparam logic [DCW-1:0] DC_TARGET = DCW'(DEBOUNCE_TICKS);
  localparam logic [RCW-1:0] RC_DELAY  = RCW'(RPT_DELAY_TICKS);
  localparam logic [RCW-1:0] RC_PERIOD = RCW'(RPT_PERIOD_TICKS);

  chan_state_t    r_state;
  logic [DCW-1:0] r_dc;
  logic [RCW-1:0] r_rc;
  logic           r_level;
  logic           r_press;
  logic           r_release;
  logic           r_evt;

  chan_state_t    w_state_nx;
  logic [DCW-1:0] w_dc_nx;
  logic [RCW-1:0] w_rc_nx;
  logic           w_level_nx;
  logic           w_press_nx;
  logic           w_release_nx;
  logic           w_evt_set;
  logic           w_evt_nx;
  logic [DCW-1:0] w_dc_inc;
  logic [RCW-1:0] w_rc_inc;

  // Saturating increments so a counter can never wrap back through zero.
  assign w_dc_inc = (r_dc == '1) ? r_dc : r_dc + 1'b1;
  assign w_rc_inc = (r_rc == '1) ? r_rc : r_rc + 1'b1;

  // Next-state, counter and output decode for the channel FSM.
  always_comb begin
    w_state_nx   = r_state;
    w_dc_nx      = r_dc;
    w_rc_nx      = r_rc;
    w_level_nx   = r_level;
    w_press_nx   = 1'b0;
    w_release_nx = 1'b0;
    w_evt_set    = 1'b0;

    case (r_state)
      RELEASED: begin
        // Any low sample restarts the press qualification window.
        if (!i_s) begin
          w_dc_nx = '0;
        end else if (i_tick) begin
          w_dc_nx = w_dc_inc;
          if (w_dc_inc == DC_TARGET) begin
            w_state_nx = HELD_DELAY;
            w_dc_nx    = '0;
            w_rc_nx    = '0;
            w_level_nx = 1'b1;
            w_press_nx = 1'b1;
            w_evt_set  = 1'b1;
          end
        end
      end

      HELD_DELAY, HELD_RPT: begin
        // Auto-repeat keeps running while a release is being qualified.
        if (i_tick) begin
          w_rc_nx = w_rc_inc;
          if ((r_state == HELD_DELAY) && (w_rc_inc == RC_DELAY)) begin
            w_evt_set  = 1'b1;
            w_rc_nx    = '0;
            w_state_nx = HELD_RPT;
          end else if ((r_state == HELD_RPT) && (w_rc_inc == RC_PERIOD)) begin
            w_evt_set = 1'b1;
            w_rc_nx   = '0;
          end
        end
        // Release qualification; a completed release overrides the repeat move.
        if (i_s) begin
          w_dc_nx = '0;
        end else if (i_tick) begin
          w_dc_nx = w_dc_inc;
          if (w_dc_inc == DC_TARGET) begin
            w_state_nx   = RELEASED;
            w_dc_nx      = '0;
            w_rc_nx      = '0;
            w_level_nx   = 1'b0;
            w_release_nx = 1'b1;
          end
        end
      end

      default: begin
        w_state_nx = RELEASED;
        w_dc_nx    = '0;
        w_rc_nx    = '0;
        w_level_nx = 1'b0;
      end
    endcase

    // A new event wins over a simultaneous acknowledge; repeated sets collapse.
    if (w_evt_set) begin
      w_evt_nx = 1'b1;
    end else if (i_ack) begin
      w_evt_nx = 1'b0;
    end else begin
      w_evt_nx = r_evt;
    end
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state   <= RELEASED;
      r_dc      <= '0;
      r_rc      <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_evt     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_dc      <= w_dc_nx;
      r_rc      <= w_rc_nx;
      r_level   <= w_level_nx;
      r_press   <= w_press_nx;
      r_release <= w_release_nx;
      r_evt     <= w_evt_nx;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_evt     = r_evt;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: shared debounce tick prescaler, per-bit two-flop
// synchronizers, and one button_channel per input bit.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN            = DEF_N_BTN,
  parameter int TICK_DIV         = DEF_TICK_DIV,
  parameter int DEBOUNCE_TICKS   = DEF_DEBOUNCE_TICKS,
  parameter int RPT_DELAY_TICKS  = DEF_RPT_DELAY_TICKS,
  parameter int RPT_PERIOD_TICKS = DEF_RPT_PERIOD_TICKS
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_BTN-1:0] btn_ack,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_evt
);

  localparam int            PW         = cnt_width(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]    r_presc;
  logic             w_tick;
  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;

  // The tick is the last count of the prescaler, one Clk wide.
  assign w_tick = (r_presc == PRESC_LAST);

  // Free-running prescaler, 0..TICK_DIV-1, shared by every channel.
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Two-flop synchronizer for the asynchronous button pins.
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    button_channel #(
      .DEBOUNCE_TICKS  (DEBOUNCE_TICKS),
      .RPT_DELAY_TICKS (RPT_DELAY_TICKS),
      .RPT_PERIOD_TICKS(RPT_PERIOD_TICKS)
    ) u_chan (
      .i_clk    (Clk),
      .i_reset_n(reset_n),
      .i_s      (r_sync2[g]),
      .i_tick   (w_tick),
      .i_ack    (btn_ack[g]),
      .o_level  (btn_level[g]),
      .o_press  (btn_press[g]),
      .o_release(btn_release[g]),
      .o_evt    (btn_evt[g])
    );
  end

endmodule
